// File: rtl/cast_rx_filter_pkg.sv
// Shared flit parameters: width, packet length and flit-type codes.
// Macros are the common params used across the cast blocks. The package mirrors them for code that prefers typed constants.
`ifndef CAST_PARAMS_SVH
`define CAST_PARAMS_SVH
`define DW          16
`define PKT_LEN     8
`define PKT_LEN_LOG 3
`define HEAD        2'b10
`define BODY        2'b00
`define TAIL        2'b01
`endif

package cast_rx_filter_pkg;
  typedef logic [1:0] flit_type_t;

  localparam int         FLIT_W      = `DW;
  localparam int         PKT_LEN     = `PKT_LEN;
  localparam int         PKT_LEN_LOG = `PKT_LEN_LOG;
  localparam flit_type_t FT_HEAD     = `HEAD;
  localparam flit_type_t FT_BODY     = `BODY;
  localparam flit_type_t FT_TAIL     = `TAIL;

  // Flit type lives in the top two bits.
  function automatic flit_type_t flit_type(input logic [`DW-1:0] f);
    return f[`DW-1:`DW-2];
  endfunction
endpackage

// File: rtl/cast_rx_filter_flit_fifo.sv
// Flit FIFO with registered storage. Output is the head entry, and there is no input-to-output bypass.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset. Entries are only observable once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/cast_rx_filter.sv
// Receive-side stream filter. Forwards packets whose head stream-id matches into a FIFO toward the converter.
// Foreign packets are dropped. A registered err_o pulse flags framing errors.
module cast_rx_filter
  import cast_rx_filter_pkg::*;
#(
  parameter logic [9:0] ACCEPT_ID  = 10'd0,
  parameter bit         ACCEPT_ALL = 1'b0,
  parameter int         DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid_i,
  input  logic [`DW-1:0] data_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [`DW-1:0] data_o,
  input  logic           ready_i,
  output logic           err_o
);
  typedef enum logic [1:0] {WAIT_HEAD, PASS, DROP} state_t;

  state_t                  state, state_nx;
  logic [`PKT_LEN_LOG-1:0] body_cnt;
  logic                    fifo_full, fifo_empty;
  logic                    acc, push, err_nx, cnt_clr, cnt_inc, id_ok;
  flit_type_t              ft;

  assign ft      = flit_type(data_i);
  assign id_ok   = ACCEPT_ALL || (data_i[9:0] == ACCEPT_ID);
  assign ready_o = (state == PASS) ? ~fifo_full : 1'b1;
  assign acc     = valid_i & ready_o;
  assign valid_o = ~fifo_empty;

  flit_fifo #(.DEPTH(DEPTH), .W(`DW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (data_i),
    .full  (fifo_full),
    .pop   (valid_o & ready_i),
    .rdata (data_o),
    .empty (fifo_empty)
  );

  // Next-state and push/error decode for each accepted flit.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    err_nx   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (acc) begin
      case (state)
        WAIT_HEAD: begin
          if (ft == `HEAD) begin
            if (id_ok) begin
              push     = 1'b1;
              cnt_clr  = 1'b1;
              state_nx = PASS;
            end else begin
              state_nx = DROP;
            end
          end else begin
            err_nx = 1'b1;
          end
        end
        PASS: begin
          push = 1'b1;
          if (ft == `HEAD) begin
            // A new head cuts the packet short. It is still honoured if its id matches.
            err_nx = 1'b1;
            if (id_ok) begin
              cnt_clr = 1'b1;
            end else begin
              push     = 1'b0;
              state_nx = DROP;
            end
          end else if (ft == `TAIL) begin
            state_nx = WAIT_HEAD;
            if (body_cnt != `PKT_LEN_LOG'(`PKT_LEN-2)) err_nx = 1'b1;
          end else if (ft == `BODY) begin
            cnt_inc = 1'b1;
          end
        end
        DROP: begin
          if (ft == `TAIL) begin
            state_nx = WAIT_HEAD;
          end else if (ft == `HEAD) begin
            err_nx = 1'b1;
            if (id_ok) begin
              push     = 1'b1;
              cnt_clr  = 1'b1;
              state_nx = PASS;
            end
          end
        end
        default: state_nx = WAIT_HEAD;
      endcase
    end
  end

  // State, body counter and registered error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= WAIT_HEAD;
      body_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state <= state_nx;
      err_o <= err_nx;
      if (cnt_clr)      body_cnt <= '0;
      else if (cnt_inc) body_cnt <= body_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cast_rx_filter.sv
// Directed bench for cast_rx_filter (ACCEPT_ID=5, DEPTH=4, PKT_LEN=8).
module tb_cast_rx_filter;
  import cast_rx_filter_pkg::*;

  localparam int W = FLIT_W;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         ready_i = 1'b1;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  cast_rx_filter #(.ACCEPT_ID(10'd5), .ACCEPT_ALL(1'b0), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         vld;
    logic [W-1:0] data;
    logic         rdy_i;
    logic         exp_rdy;
    logic         exp_vld;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] rx[$];
  int           err_seen = 0;

  function automatic logic [W-1:0] mk_head(input logic [9:0] id);
    return {FT_HEAD, 4'h0, id};
  endfunction
  function automatic logic [W-1:0] mk_body(input logic [3:0] n);
    return {FT_BODY, n, 10'h000};
  endfunction
  function automatic logic [W-1:0] mk_tail();
    return {FT_TAIL, 4'hF, 10'h000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [W-1:0] d, input logic ri, input logic er,
                     input logic ev, input logic [W-1:0] ed, input logic ee);
    vec_t t;
    t.vld = v; t.data = d; t.rdy_i = ri; t.exp_rdy = er;
    t.exp_vld = ev; t.exp_data = ed; t.exp_err = ee;
    vecs.push_back(t);
  endtask

  // Matched 8-flit packet with ready_i=1: each flit appears one cycle after acceptance.
  task automatic add_matched(input logic first_err);
    logic [W-1:0] prev, f;
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      f = (k == 0) ? mk_head(10'd5) : (k == 7) ? mk_tail() : mk_body(4'(k));
      add(1'b1, f, 1'b1, 1'b1, (k > 0), prev, (k == 0) ? first_err : 1'b0);
      prev = f;
    end
    add(1'b0, '0, 1'b1, 1'b1, 1'b1, mk_tail(), 1'b0);
    add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  // Hold a flit until accepted, with a bounded wait.
  task automatic send(input logic [W-1:0] f);
    logic got;
    got = 1'b0;
    valid_i = 1'b1;
    data_i  = f;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout act=%0h exp=%0h", 0, 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor of delivered flits and error pulses.
  always @(negedge clk) begin
    if (rstn && valid_o && ready_i) rx.push_back(data_o);
    if (rstn && err_o) err_seen++;
  end

  initial begin
    logic [W-1:0] exp_q[$];

    // Table: matched packet, foreign packet, orphan body, then a matched packet.
    add_matched(1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b1, (k == 0) ? mk_head(10'd3) : (k == 7) ? mk_tail() : mk_body(4'(k)),
          1'b1, 1'b1, 1'b0, '0, 1'b0);
    add(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    add(1'b1, mk_body(4'd9), 1'b1, 1'b1, 1'b0, '0, 1'b0);
    add_matched(1'b1);

    // Reset state
    #2;
    chk("rst_ready_o", 32'(ready_o), 1);
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_err_o",   32'(err_o),   0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      valid_i = vecs[i].vld;
      data_i  = vecs[i].data;
      ready_i = vecs[i].rdy_i;
      @(negedge clk);
      chk($sformatf("v%0d_ready_o", i), 32'(ready_o), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_valid_o", i), 32'(valid_o), 32'(vecs[i].exp_vld));
      chk($sformatf("v%0d_err_o",   i), 32'(err_o),   32'(vecs[i].exp_err));
      if (vecs[i].exp_vld)
        chk($sformatf("v%0d_data_o", i), 32'(data_o), 32'(vecs[i].exp_data));
      @(posedge clk); #1;
    end
    valid_i = 1'b0;

    // Short packet: 4 bodies, so the tail is forwarded and flagged once.
    idle(2);
    rx.delete(); err_seen = 0; ready_i = 1'b1;
    exp_q = {mk_head(10'd5), mk_body(4'd1), mk_body(4'd2), mk_body(4'd3), mk_body(4'd4), mk_tail()};
    foreach (exp_q[i]) send(exp_q[i]);
    chk("short_err_after_tail", 32'(err_o), 1);
    idle(4);
    chk("short_rx_count", 32'(rx.size()), 6);
    chk("short_err_count", 32'(err_seen), 1);
    for (int i = 0; i < 6 && i < rx.size(); i++)
      chk($sformatf("short_rx%0d", i), 32'(rx[i]), 32'(exp_q[i]));

    // Backpressure: four accepts fill the FIFO, and a full pop still holds ready_o low.
    rx.delete(); err_seen = 0; ready_i = 1'b0;
    exp_q = {mk_head(10'd5), mk_body(4'd1), mk_body(4'd2), mk_body(4'd3),
             mk_body(4'd4), mk_body(4'd5), mk_body(4'd6), mk_tail()};
    for (int i = 0; i < 4; i++) send(exp_q[i]);
    valid_i = 1'b1; data_i = exp_q[4];
    @(negedge clk);
    chk("bp_full_ready_o", 32'(ready_o), 0);
    chk("bp_full_valid_o", 32'(valid_o), 1);
    chk("bp_hold_data0",   32'(data_o),  32'(exp_q[0]));
    @(posedge clk); #1;
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_full_pop_ready_o", 32'(ready_o), 0);
    chk("bp_hold_data1",       32'(data_o),  32'(exp_q[0]));
    @(posedge clk); #1;
    for (int i = 4; i < 8; i++) send(exp_q[i]);
    idle(6);
    chk("bp_rx_count", 32'(rx.size()), 8);
    chk("bp_err_count", 32'(err_seen), 0);
    for (int i = 0; i < 8 && i < rx.size(); i++)
      chk($sformatf("bp_rx%0d", i), 32'(rx[i]), 32'(exp_q[i]));

    // Reset mid-packet with head and two bodies buffered.
    ready_i = 1'b0;
    send(mk_head(10'd5)); send(mk_body(4'd1)); send(mk_body(4'd2));
    chk("pre_rst_valid_o", 32'(valid_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid_o", 32'(valid_o), 0);
    chk("mid_rst_ready_o", 32'(ready_o), 1);
    chk("mid_rst_err_o",   32'(err_o),   0);
    @(negedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(mk_body(4'd3));
    chk("post_rst_body_err", 32'(err_o), 1);
    chk("post_rst_valid_o",  32'(valid_o), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
